// File: rtl/store_buffer.sv
// Store buffer: holds speculative stores until ROB commit, then drains them
// to data memory in program order over a valid/ready write port.
module store_buffer #(
    parameter int unsigned SB_SIZE = 4,
    parameter int unsigned IDX_W   = $clog2(SB_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_valid_i,
    input  logic [31:0]      alloc_addr_i,
    input  logic [31:0]      alloc_data_i,
    input  logic [1:0]       alloc_size_i,
    output logic [IDX_W-1:0] alloc_idx_o,
    output logic             full_o,
    output logic             empty_o,
    input  logic             commit_valid_i,
    input  logic             commit_store_to_mem_i,
    input  logic [IDX_W-1:0] commit_store_buffer_idx_i,
    input  logic             flush_i,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    output logic [3:0]       mem_be_o,
    input  logic [31:0]      ld_addr_i,
    output logic             ld_conflict_o
);
    localparam int unsigned CW = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_PENDING,
        ST_COMMITTED
    } entry_state_e;

    entry_state_e      r_state [SB_SIZE];
    logic [29:0]       r_addr  [SB_SIZE];
    logic [31:0]       r_data  [SB_SIZE];
    logic [3:0]        r_be    [SB_SIZE];
    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [CW-1:0]     r_count;

    entry_state_e      w_state_next [SB_SIZE];
    logic              w_full;
    logic              w_alloc;
    logic              w_commit;
    logic              w_req_valid;
    logic              w_drain;
    logic [IDX_W-1:0]  w_head_next;
    logic [CW-1:0]     w_ccount;
    logic [3:0]        w_alloc_be;
    logic [31:0]       w_alloc_data;
    logic              w_conflict;

    assign w_full      = (r_count == CW'(SB_SIZE));
    assign w_alloc     = alloc_valid_i && !w_full && !flush_i;
    assign w_commit    = commit_valid_i && commit_store_to_mem_i &&
                         (r_state[commit_store_buffer_idx_i] == ST_PENDING);
    assign w_req_valid = (r_state[r_head] == ST_COMMITTED);
    assign w_drain     = w_req_valid && mem_req_ready_i;
    assign w_head_next = r_head + IDX_W'(w_drain);

    always_comb begin
        w_alloc_be   = 4'hF;
        w_alloc_data = alloc_data_i;
        case (alloc_size_i)
            2'd0: begin
                w_alloc_be   = 4'b0001 << alloc_addr_i[1:0];
                w_alloc_data = {4{alloc_data_i[7:0]}};
            end
            2'd1: begin
                w_alloc_be   = alloc_addr_i[1] ? 4'b1100 : 4'b0011;
                w_alloc_data = {2{alloc_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Commit is applied before flush so a same-cycle committed store survives.
    always_comb begin
        w_ccount = '0;
        for (int unsigned i = 0; i < SB_SIZE; i++) begin
            w_state_next[i] = r_state[i];
            if (w_alloc && (r_tail == IDX_W'(i)))
                w_state_next[i] = ST_PENDING;
            if (w_commit && (commit_store_buffer_idx_i == IDX_W'(i)))
                w_state_next[i] = ST_COMMITTED;
            if (w_drain && (r_head == IDX_W'(i)))
                w_state_next[i] = ST_FREE;
            if (flush_i && (w_state_next[i] == ST_PENDING))
                w_state_next[i] = ST_FREE;
            w_ccount = w_ccount + CW'(w_state_next[i] == ST_COMMITTED);
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int unsigned i = 0; i < SB_SIZE; i++) begin
            if ((r_state[i] != ST_FREE) && (r_addr[i] == ld_addr_i[31:2]))
                w_conflict = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SB_SIZE; i++)
                r_state[i] <= ST_FREE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < SB_SIZE; i++)
                r_state[i] <= w_state_next[i];
            if (w_alloc) begin
                r_addr[r_tail] <= alloc_addr_i[31:2];
                r_data[r_tail] <= w_alloc_data;
                r_be[r_tail]   <= w_alloc_be;
            end
            r_head <= w_head_next;
            // Committed entries are contiguous from head, so tail re-anchors there.
            if (flush_i) begin
                r_tail  <= w_head_next + w_ccount[IDX_W-1:0];
                r_count <= w_ccount;
            end else begin
                if (w_alloc)
                    r_tail <= r_tail + 1'b1;
                r_count <= r_count + CW'(w_alloc) - CW'(w_drain);
            end
        end
    end

    assign alloc_idx_o     = r_tail;
    assign full_o          = w_full;
    assign empty_o         = (r_count == '0);
    assign mem_req_valid_o = w_req_valid;
    assign mem_addr_o      = w_req_valid ? {r_addr[r_head], 2'b00} : '0;
    assign mem_data_o      = w_req_valid ? r_data[r_head] : '0;
    assign mem_be_o        = w_req_valid ? r_be[r_head] : '0;
    assign ld_conflict_o   = w_conflict;
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain order, byte enables,
// flush interaction, load conflict and reset behaviour.
module tb_store_buffer;
    localparam int unsigned SB_SIZE = 4;
    localparam int unsigned IDX_W   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_valid;
    logic [31:0]      alloc_addr;
    logic [31:0]      alloc_data;
    logic [1:0]       alloc_size;
    logic [IDX_W-1:0] alloc_idx;
    logic             full;
    logic             empty;
    logic             commit_valid;
    logic             commit_store;
    logic [IDX_W-1:0] commit_idx;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic [3:0]       mem_be;
    logic [31:0]      ld_addr;
    logic             ld_conflict;

    int n_checks = 0;
    int n_errors = 0;

    store_buffer #(.SB_SIZE(SB_SIZE), .IDX_W(IDX_W)) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .alloc_valid_i             (alloc_valid),
        .alloc_addr_i              (alloc_addr),
        .alloc_data_i              (alloc_data),
        .alloc_size_i              (alloc_size),
        .alloc_idx_o               (alloc_idx),
        .full_o                    (full),
        .empty_o                   (empty),
        .commit_valid_i            (commit_valid),
        .commit_store_to_mem_i     (commit_store),
        .commit_store_buffer_idx_i (commit_idx),
        .flush_i                   (flush),
        .mem_req_valid_o           (req_valid),
        .mem_req_ready_i           (req_ready),
        .mem_addr_o                (mem_addr),
        .mem_data_o                (mem_data),
        .mem_be_o                  (mem_be),
        .ld_addr_i                 (ld_addr),
        .ld_conflict_o             (ld_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        alloc_data  = d;
        alloc_size  = s;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic commit(input logic [IDX_W-1:0] idx);
        commit_valid = 1'b1;
        commit_store = 1'b1;
        commit_idx   = idx;
        tick();
        commit_valid = 1'b0;
        commit_store = 1'b0;
    endtask

    // Upstream must never offer a store while the buffer is full.
    always @(negedge clk) begin
        if (!rst)
            check("no_alloc_when_full", {31'b0, alloc_valid & full}, 32'd0);
    end

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_addr = '0; alloc_data = '0; alloc_size = '0;
        commit_valid = 1'b0; commit_store = 1'b0; commit_idx = '0; flush = 1'b0;
        req_ready = 1'b0; ld_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_full",     {31'b0, full}, 32'd0);
        check("rst_empty",    {31'b0, empty}, 32'd1);
        check("rst_idx",      {30'b0, alloc_idx}, 32'd0);
        check("rst_valid",    {31'b0, req_valid}, 32'd0);
        check("rst_addr",     mem_addr, 32'd0);
        check("rst_data",     mem_data, 32'd0);
        check("rst_be",       {28'b0, mem_be}, 32'd0);
        check("rst_conflict", {31'b0, ld_conflict}, 32'd0);

        // Word store, commit, one-cycle commit-to-request latency
        alloc(32'h100, 32'hDEADBEEF, 2'd2);
        check("w_empty_after_alloc", {31'b0, empty}, 32'd0);
        check("w_idx_after_alloc",   {30'b0, alloc_idx}, 32'd1);
        check("w_pending_no_req",    {31'b0, req_valid}, 32'd0);
        req_ready = 1'b1;
        commit(2'd0);
        check("w_req_valid", {31'b0, req_valid}, 32'd1);
        check("w_req_addr",  mem_addr, 32'h100);
        check("w_req_be",    {28'b0, mem_be}, 32'hF);
        check("w_req_data",  mem_data, 32'hDEADBEEF);
        tick();
        req_ready = 1'b0;
        check("w_drained_valid", {31'b0, req_valid}, 32'd0);
        check("w_drained_empty", {31'b0, empty}, 32'd1);

        // Byte and half stores (entries 1 and 2)
        alloc(32'h203, 32'h0000005A, 2'd0);
        alloc(32'h206, 32'h00001234, 2'd1);
        commit(2'd1);
        commit(2'd2);
        check("b_valid", {31'b0, req_valid}, 32'd1);
        check("b_addr",  mem_addr, 32'h200);
        check("b_be",    {28'b0, mem_be}, 32'h8);
        check("b_data",  mem_data, 32'h5A5A5A5A);
        req_ready = 1'b1;
        tick();
        check("h_addr", mem_addr, 32'h204);
        check("h_be",   {28'b0, mem_be}, 32'hC);
        check("h_data", mem_data, 32'h12341234);
        tick();
        req_ready = 1'b0;
        check("bh_empty", {31'b0, empty}, 32'd1);

        // Fill, wrap, stalled drain, in-order drain
        do_reset();
        for (int k = 0; k < 4; k++)
            alloc(32'h400 + 32'(4 * k), 32'h1000 + 32'(k), 2'd2);
        check("fill_full", {31'b0, full}, 32'd1);
        check("fill_idx",  {30'b0, alloc_idx}, 32'd0);
        for (int k = 0; k < 4; k++)
            commit(2'(k));
        check("stall_addr", mem_addr, 32'h400);
        tick();
        check("stall_valid_held", {31'b0, req_valid}, 32'd1);
        check("stall_addr_held",  mem_addr, 32'h400);
        check("stall_data_held",  mem_data, 32'h1000);
        req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("order_valid", {31'b0, req_valid}, 32'd1);
            check("order_addr",  mem_addr, 32'h400 + 32'(4 * k));
            check("order_data",  mem_data, 32'h1000 + 32'(k));
            tick();
        end
        req_ready = 1'b0;
        check("fill_drained_empty", {31'b0, empty}, 32'd1);
        check("fill_drained_full",  {31'b0, full}, 32'd0);

        // Flush frees pending entries, committed head survives
        do_reset();
        alloc(32'h500, 32'hA0, 2'd2);
        alloc(32'h504, 32'hA1, 2'd2);
        alloc(32'h508, 32'hA2, 2'd2);
        commit(2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_idx",   {30'b0, alloc_idx}, 32'd1);
        check("fl_valid", {31'b0, req_valid}, 32'd1);
        check("fl_addr",  mem_addr, 32'h500);
        ld_addr = 32'h504;
        #1;
        check("fl_freed_conflict", {31'b0, ld_conflict}, 32'd0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("fl_empty", {31'b0, empty}, 32'd1);
        check("fl_idx2",  {30'b0, alloc_idx}, 32'd1);

        // Same-cycle commit + flush + alloc
        do_reset();
        alloc(32'h600, 32'hB0, 2'd2);
        alloc(32'h604, 32'hB1, 2'd2);
        commit(2'd0);
        commit_valid = 1'b1; commit_store = 1'b1; commit_idx = 2'd1;
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_addr = 32'h608; alloc_data = 32'hB2; alloc_size = 2'd2;
        tick();
        commit_valid = 1'b0; commit_store = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
        check("cf_idx", {30'b0, alloc_idx}, 32'd2);
        ld_addr = 32'h608;
        #1;
        check("cf_dropped_alloc", {31'b0, ld_conflict}, 32'd0);
        check("cf_addr0", mem_addr, 32'h600);
        req_ready = 1'b1;
        tick();
        check("cf_valid1", {31'b0, req_valid}, 32'd1);
        check("cf_addr1",  mem_addr, 32'h604);
        check("cf_data1",  mem_data, 32'hB1);
        tick();
        req_ready = 1'b0;
        check("cf_empty", {31'b0, empty}, 32'd1);

        // Load conflict
        do_reset();
        alloc(32'h300, 32'hC0, 2'd2);
        ld_addr = 32'h302;
        #1;
        check("ld_same_word", {31'b0, ld_conflict}, 32'd1);
        ld_addr = 32'h304;
        #1;
        check("ld_next_word", {31'b0, ld_conflict}, 32'd0);
        ld_addr = 32'h300;
        commit(2'd0);
        check("ld_committed", {31'b0, ld_conflict}, 32'd1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("ld_after_drain", {31'b0, ld_conflict}, 32'd0);

        // Reset during a stalled request drops it
        alloc(32'h700, 32'hD0, 2'd2);
        commit(2'd1);
        check("rd_valid", {31'b0, req_valid}, 32'd1);
        do_reset();
        check("rd_valid_dropped", {31'b0, req_valid}, 32'd0);
        check("rd_empty",         {31'b0, empty}, 32'd1);
        check("rd_idx",           {30'b0, alloc_idx}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the memory/execute stage and data memory, directly downstream of ROB commit.
- Holds stores speculatively from execute until the ROB commits them, then drains them to memory in program order over a valid/ready port.
- Its entry index travels with the instruction to writeback and returns on the ROB commit interface.
- A branch-taken flush discards uncommitted stores; committed stores always drain.

Parameters:
SB_SIZE, 4, number of entries (power of two, >=2)
IDX_W, $clog2(SB_SIZE), entry index width (matches store_buffer_idx_t)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
alloc_valid_i  in  1  execute stage inserts a store this cycle
alloc_addr_i  in  32  byte address of store
alloc_data_i  in  32  store data, right-aligned
alloc_size_i  in  2  0=byte, 1=half, 2=word (3 treated as word)
alloc_idx_o  out  IDX_W  index that the inserted store receives (tail pointer)
full_o  out  1  no free entry; upstream must stall stores
empty_o  out  1  all entries FREE
commit_valid_i  in  1  ROB commit this cycle
commit_store_to_mem_i  in  1  committed instruction is a store
commit_store_buffer_idx_i  in  IDX_W  entry of committed store
flush_i  in  1  committed taken branch; drop speculative stores
mem_req_valid_o  out  1  write request to memory
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_data_o  out  32  lane-replicated data
mem_be_o  out  4  byte enables
ld_addr_i  in  32  address of load in memory stage
ld_conflict_o  out  1  load overlaps a non-FREE entry; load must stall

Behaviour:
- Entry state: FREE -> PENDING (alloc) -> COMMITTED (ROB commit) -> FREE (memory handshake).
- Each entry stores word address, data and byte enables, all computed at alloc.
- Pointers: head (oldest), tail (next alloc), count 0..SB_SIZE. Both pointers wrap modulo SB_SIZE.
- Outputs: full_o = (count==SB_SIZE); empty_o = (count==0); alloc_idx_o = tail.
- Alloc:
  - If alloc_valid_i && !full_o && !flush_i, entry[tail] becomes PENDING next cycle and tail increments.
  - Alloc while full is ignored; the bench asserts this never happens.
- Byte enables and data:
  - byte: be = 4'b0001 << addr[1:0], data = {4{d[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011, data = {2{d[15:0]}}; addr[0] is ignored (misaligned stores are not supported).
  - word: be = 4'hF, data = d.
- Commit:
  - If commit_valid_i && commit_store_to_mem_i and entry[idx] is PENDING, the entry becomes COMMITTED next cycle.
  - Commit to a non-PENDING entry is ignored.
- Drain:
  - mem_req_valid_o = entry[head] is COMMITTED, decoded combinationally from registered state.
  - mem_addr_o, mem_data_o and mem_be_o reflect entry[head] and stay stable while valid && !ready.
  - On valid && ready, entry[head] becomes FREE and head increments next cycle.
  - When mem_req_valid_o=0, the memory outputs are driven to 0.
- Commit and drain in the same cycle on the same entry: drain sees the registered state (PENDING), so the request issues the following cycle. Minimum commit-to-request latency is 1 cycle.
- Flush (flush_i=1):
  - All PENDING entries become FREE and any same-cycle alloc is dropped.
  - A commit in the same cycle is applied before the flush, so that store survives.
  - COMMITTED entries and a same-cycle drain handshake are unaffected.
  - Next state: tail = head_next + committed_count_next; count = committed_count_next. Committed entries are always contiguous from head.
- Count update: count_next = count + alloc_accepted - drain_fire, or committed_count_next on flush.
- Load conflict: ld_conflict_o = 1 if any non-FREE entry has word address == ld_addr_i[31:2]. This is purely combinational; there is no forwarding.
- Reset (rst_i=1 at a clock edge):
  - All entries FREE; head = tail = count = 0.
  - Outputs: full_o=0, empty_o=1, alloc_idx_o=0, mem_req_valid_o=0, mem_addr_o/mem_data_o/mem_be_o=0, ld_conflict_o=0.
  - Reset mid-drain drops the request without waiting for ready.

Test Plan:
- Reset, then alloc a word store 0x100 / 0xDEADBEEF; commit idx 0; ready=1 -> mem_req_valid_o high 1 cycle after commit with addr 0x100, be 4'hF, data 0xDEADBEEF; then empty_o=1.
- Byte store addr 0x203, data 0x5A -> be=4'b1000, data=0x5A5A5A5A, addr 0x200. Half store addr 0x206 -> be=4'b1100.
- Alloc 4 stores with ready=0 -> full_o=1 and alloc_idx_o wraps to 0. Commit all, then raise ready -> four requests drain in index order 0,1,2,3 with data held stable while stalled.
- Alloc idx 0..2, commit idx 0 only, then flush_i -> idx 1 and 2 freed, tail=1, count=1, idx 0 still drains. A new alloc then receives alloc_idx_o=1.
- Same-cycle commit idx 1 + flush, with idx 0 COMMITTED -> both 0 and 1 drain and tail=2. A same-cycle alloc with flush is dropped.
- Pending store to 0x300 and load at 0x302 -> ld_conflict_o=1. Load at 0x304 -> 0. After the 0x300 store drains -> 0.
